// File: rtl/dlfloat_cmp_reduce.sv
// Sign-magnitude float compare unit: pairwise min/max/eq/lt/le plus streaming min/max reduction.
// Define DLFCMP_NAN_EN to treat the all-ones exponent+mantissa encoding as NaN.
module dlfloat_cmp_reduce #(
   parameter int EXP_W = 6,
   parameter int MAN_W = 9,
   parameter int IDX_W = 8,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [2:0]       sel,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic [IDX_W-1:0] out_idx
);

`ifdef DLFCMP_NAN_EN
   localparam bit NAN_EN = 1'b1;
`else
   localparam bit NAN_EN = 1'b0;
`endif

   typedef enum logic {IDLE, ACC} state_t;

   state_t           state;
   logic [W-1:0]     acc;
   logic [IDX_W-1:0] best_idx;
   logic [IDX_W-1:0] cnt;
   logic             op_max;
   logic             acc_ok;

   logic             accept;
   logic             a_nan;
   logic             b_nan;
   logic             pair_lt;
   logic             pair_gt;
   logic             pair_eq;
   logic [W-1:0]     pair_res;
   logic             red_max;
   logic             better;
   logic             take;
   logic [W-1:0]     new_acc;
   logic [IDX_W-1:0] new_idx;

   function automatic logic is_zero(input logic [W-1:0] x);
      return x[W-2:0] == '0;
   endfunction

   function automatic logic is_nan(input logic [W-1:0] x);
      return NAN_EN && (&x[W-2:0]);
   endfunction

   function automatic logic f_eq(input logic [W-1:0] x, input logic [W-1:0] y);
      return (x == y) || (is_zero(x) && is_zero(y));
   endfunction

   // Strict x < y; magnitude order flips when both operands are negative.
   function automatic logic f_lt(input logic [W-1:0] x, input logic [W-1:0] y);
      if (is_zero(x) && is_zero(y))
         return 1'b0;
      if (x[W-1] != y[W-1])
         return x[W-1];
      if (x[W-1])
         return x[W-2:0] > y[W-2:0];
      return x[W-2:0] < y[W-2:0];
   endfunction

   assign accept   = in_valid && in_ready;
   assign in_ready = (state == ACC) || !out_valid || out_ready;

   always_comb begin
      a_nan   = is_nan(a);
      b_nan   = is_nan(b);
      pair_lt = f_lt(a, b);
      pair_gt = f_lt(b, a);
      pair_eq = f_eq(a, b);
      pair_res = '0;
      case (sel)
         3'b001: begin
            if (b_nan)
               pair_res = a;
            else if (a_nan)
               pair_res = b;
            else
               pair_res = (pair_lt || pair_eq) ? a : b;
         end
         3'b010: begin
            if (b_nan)
               pair_res = a;
            else if (a_nan)
               pair_res = b;
            else
               pair_res = (pair_gt || pair_eq) ? a : b;
         end
         3'b011:  pair_res = (a_nan || b_nan) ? '0 : {W{pair_eq}};
         3'b100:  pair_res = (a_nan || b_nan) ? '0 : {W{pair_lt}};
         3'b101:  pair_res = (a_nan || b_nan) ? '0 : {W{pair_lt || pair_eq}};
         default: pair_res = '0;
      endcase
   end

   // acc_ok stays low until a non-NaN element arrives; acc then holds the first element.
   always_comb begin
      red_max = (state == ACC) ? op_max : sel[0];
      better  = red_max ? f_lt(acc, a) : f_lt(a, acc);
      take    = !a_nan && (!acc_ok || better);
      new_acc = take ? a : acc;
      new_idx = take ? cnt : best_idx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         best_idx  <= '0;
         cnt       <= '0;
         op_max    <= 1'b0;
         acc_ok    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (accept) begin
            case (state)
               IDLE: begin
                  if (sel[2:1] == 2'b11) begin
                     if (in_last) begin
                        out_valid <= 1'b1;
                        out_data  <= a;
                        out_idx   <= '0;
                     end else begin
                        state    <= ACC;
                        acc      <= a;
                        best_idx <= '0;
                        cnt      <= IDX_W'(1);
                        op_max   <= sel[0];
                        acc_ok   <= !a_nan;
                     end
                  end else begin
                     out_valid <= 1'b1;
                     out_data  <= pair_res;
                     out_idx   <= '0;
                  end
               end
               ACC: begin
                  acc      <= new_acc;
                  best_idx <= new_idx;
                  acc_ok   <= acc_ok || !a_nan;
                  cnt      <= cnt + 1'b1;
                  if (in_last) begin
                     out_valid <= 1'b1;
                     out_data  <= new_acc;
                     out_idx   <= new_idx;
                     state     <= IDLE;
                     cnt       <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dlfloat_cmp_reduce.sv
// Scoreboard bench for dlfloat_cmp_reduce (16-bit default geometry).
`timescale 1ns/1ps
module tb_dlfloat_cmp_reduce;

`ifdef DLFCMP_NAN_EN
   localparam bit NAN_EN = 1'b1;
`else
   localparam bit NAN_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic [2:0]  sel = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [7:0]  out_idx;

   int          checks = 0;
   int          errors = 0;
   logic [23:0] sb_q[$];
   logic [23:0] sb_e;
   bit          rand_rdy = 1'b0;
   bit          rdy_force = 1'b1;
   int          cyc = 0;

   bit          in_pkt = 1'b0;
   bit          pk_max;
   bit          pk_ok;
   logic [15:0] pk_acc;
   int          pk_idx;
   int          pk_cnt;

   dlfloat_cmp_reduce #(.EXP_W(6), .MAN_W(9), .IDX_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sel(sel), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int key(input logic [15:0] x);
      int m;
      m = int'({17'b0, x[14:0]});
      return x[15] ? -m : m;
   endfunction

   function automatic bit nan(input logic [15:0] x);
      return NAN_EN && (x[14:0] == 15'h7FFF);
   endfunction

   function automatic logic [15:0] exp_pair(input logic [15:0] xa, input logic [15:0] xb, input logic [2:0] xs);
      bit anyn;
      anyn = nan(xa) || nan(xb);
      case (xs)
         3'b001: return nan(xb) ? xa : nan(xa) ? xb : (key(xa) <= key(xb)) ? xa : xb;
         3'b010: return nan(xb) ? xa : nan(xa) ? xb : (key(xa) >= key(xb)) ? xa : xb;
         3'b011: return (!anyn && key(xa) == key(xb)) ? 16'hFFFF : 16'h0000;
         3'b100: return (!anyn && key(xa) <  key(xb)) ? 16'hFFFF : 16'h0000;
         3'b101: return (!anyn && key(xa) <= key(xb)) ? 16'hFFFF : 16'h0000;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic model_beat(input logic [15:0] xa, input logic [15:0] xb, input logic [2:0] xs, input logic xl);
      if (!in_pkt && xs[2:1] != 2'b11) begin
         sb_q.push_back({exp_pair(xa, xb, xs), 8'h00});
      end else begin
         if (!in_pkt) begin
            pk_max = xs[0];
            pk_acc = xa;
            pk_idx = 0;
            pk_cnt = 0;
            pk_ok  = !nan(xa);
         end else if (!nan(xa) && (!pk_ok ||
                    (pk_max ? key(xa) > key(pk_acc) : key(xa) < key(pk_acc)))) begin
            pk_acc = xa;
            pk_idx = pk_cnt;
            pk_ok  = 1'b1;
         end
         pk_cnt++;
         if (xl) begin
            sb_q.push_back({pk_acc, 8'(pk_idx)});
            in_pkt = 1'b0;
         end else begin
            in_pkt = 1'b1;
         end
      end
   endtask

   task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic [2:0] xs, input logic xl);
      int unsigned guard;
      bit done;
      bit ok;
      guard = 0;
      done = 1'b0;
      a = xa; b = xb; sel = xs; in_last = xl; in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         if (ok) begin
            model_beat(xa, xb, xs, xl);
            done = 1'b1;
         end else begin
            guard++;
            if (guard > 50) begin
               check("accept_timeout", 0, 1);
               done = 1'b1;
            end
         end
      end
      #1 in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic drain();
      int unsigned guard;
      guard = 0;
      while (sb_q.size() != 0 && guard < 200) begin
         @(posedge clk);
         guard++;
      end
      if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      #3 rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_idx", out_idx, 0);
      sb_q.delete();
      in_pkt = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // out_ready only ever changes just after a rising edge
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_out", 1, 0);
            end else begin
               sb_e = sb_q.pop_front();
               check("out_data", out_data, sb_e[23:8]);
               check("out_idx", out_idx, sb_e[7:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int c0;
      logic [15:0] ra;
      logic [15:0] rb;
      #1;
      check("init_out_valid", out_valid, 0);
      check("init_out_data", out_data, 0);
      check("init_out_idx", out_idx, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      send(16'h4200, 16'hC200, 3'b001, 1'b0);
      send(16'h4200, 16'hC200, 3'b010, 1'b0);
      send(16'h0000, 16'h8000, 3'b011, 1'b0);
      send(16'h0000, 16'h8000, 3'b100, 1'b0);
      send(16'h8000, 16'h0000, 3'b101, 1'b0);
      send(16'hC200, 16'hC400, 3'b100, 1'b0);
      send(16'h1234, 16'h5678, 3'b000, 1'b0);
      send(16'h7FFF, 16'h3E00, 3'b101, 1'b0);
      send(16'h7FFF, 16'h3E00, 3'b001, 1'b0);
      send(16'h7FFF, 16'h3E00, 3'b010, 1'b0);

      send(16'h4400, 16'h0, 3'b110, 1'b0);
      send(16'h3E00, 16'h0, 3'b000, 1'b0);
      send(16'hC000, 16'h0, 3'b010, 1'b0);
      send(16'hC000, 16'h0, 3'b110, 1'b1);
      send(16'h1234, 16'h0, 3'b111, 1'b1);
      send(16'h8000, 16'h0, 3'b111, 1'b0);
      send(16'h0000, 16'h0, 3'b111, 1'b1);
      send(16'h3E00, 16'h0, 3'b111, 1'b0);
      send(16'h7FFF, 16'h0, 3'b111, 1'b0);
      send(16'h4000, 16'h0, 3'b111, 1'b1);
      drain();

      // held output under backpressure
      rdy_force = 1'b0;
      @(posedge clk); #2;
      send(16'h4200, 16'hC200, 3'b001, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_in_ready", in_ready, 0);
         check("hold_out_valid", out_valid, 1);
         check("hold_out_data", out_data, 16'hC200);
      end
      rdy_force = 1'b1;
      drain();

      c0 = cyc;
      for (int i = 0; i < 4; i++) send(16'(i * 16'h0400), 16'h2000, 3'b010, 1'b0);
      check("b2b_cycles", cyc - c0, 4);
      drain();

      // long packet: winner at position 258 reports index 2
      for (int i = 0; i < 260; i++) begin
         ra = (i == 258) ? 16'h7000 : 16'h0100 + 16'($urandom_range(0, 255));
         send(ra, 16'h0, 3'b111, i == 259);
      end
      drain();

      rand_rdy = 1'b1;
      for (int i = 0; i < 60; i++) begin
         ra = 16'($urandom);
         rb = (i % 4 == 0) ? ra ^ 16'h8000 : 16'($urandom);
         if (i % 7 == 0) ra = 16'h7FFF;
         if (i % 10 == 3) begin
            send(ra, rb, 3'b110, 1'b0);
            send(rb, ra, 3'b110, 1'b0);
            send(16'($urandom), ra, 3'b000, 1'b1);
         end else begin
            send(ra, rb, 3'($urandom_range(0, 5)), 1'b0);
         end
      end
      rand_rdy = 1'b0;
      drain();

      // reset with a pending result
      rdy_force = 1'b0;
      @(posedge clk); #2;
      send(16'h4200, 16'hC200, 3'b010, 1'b0);
      do_reset();
      rdy_force = 1'b1;
      @(posedge clk); #2;

      // reset mid-packet, then a fresh single-beat packet
      send(16'h4400, 16'h0, 3'b111, 1'b0);
      send(16'h3E00, 16'h0, 3'b111, 1'b0);
      do_reset();
      send(16'h1234, 16'h0, 3'b111, 1'b1);
      drain();

      check("sb_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
